mult_sched: RTL

//  Scheduler for the multiplier FU bank. Steers each issued mult op to a free FU.

---
 rtl/rv32i_types.sv | 26 ++
 rtl/mult_sched_if.sv | 53 +++++
 rtl/rr_arbiter.sv | 42 ++++
 rtl/mult_sched.sv | 138 +++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// +------------------------------------------------------------------+
// | rv32i_types : shared core types for the multiplier FU scheduler  |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
`default_nettype none

package rv32i_types;

  localparam int NUM_MULT_UNITS = 2;
  localparam int MULT_IDX_W     = (NUM_MULT_UNITS > 1) ? $clog2(NUM_MULT_UNITS) : 1;

  typedef struct packed {
    logic [3:0]  rob_idx;
    logic [2:0]  funct3;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
  } issue_fu_data_t;

  typedef struct packed {
    logic [3:0]  rob_idx;
    logic [31:0] result;
  } fu_cdb_data_t;

endpackage

`default_nettype wire

// File: rtl/mult_sched_if.sv
// +------------------------------------------------------------------+
// | mult_sched_if : RS / FU-array / CDB bundle of the mult scheduler |
// | Optional MULT_SCHED_PERF_EN adds the performance counter outputs |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
`default_nettype none

interface mult_sched_if #(
  parameter int NUM_UNITS = rv32i_types::NUM_MULT_UNITS
) ();
  import rv32i_types::*;

  logic                                 branch_mispredict;
  logic                                 issue_valid;
  issue_fu_data_t                       issue_data;
  logic                                 issue_ready;
  issue_fu_data_t [NUM_UNITS-1:0]       fu_input_data;
  logic [NUM_UNITS-1:0]                 fu_start;
  logic [NUM_UNITS-1:0]                 fu_busy;
  logic [NUM_UNITS-1:0]                 fu_done;
  fu_cdb_data_t [NUM_UNITS-1:0]         fu_output_data;
  logic [NUM_UNITS-1:0]                 cdb_ack;
  logic                                 cdb_valid;
  fu_cdb_data_t                         cdb_data;
  logic                                 cdb_accept;
`ifdef MULT_SCHED_PERF_EN
  logic [31:0]                          perf_issues;
  logic [31:0]                          perf_stalls;
  logic [31:0]                          perf_cdb_blocked;
`endif

  // slave is the scheduler; master is the surrounding RS / FU / CDB environment
  modport slave (
`ifdef MULT_SCHED_PERF_EN
    output perf_issues, perf_stalls, perf_cdb_blocked,
`endif
    input  branch_mispredict, issue_valid, issue_data, fu_busy, fu_done,
    input  fu_output_data, cdb_accept,
    output issue_ready, fu_input_data, fu_start, cdb_ack, cdb_valid, cdb_data
  );

  modport master (
`ifdef MULT_SCHED_PERF_EN
    input  perf_issues, perf_stalls, perf_cdb_blocked,
`endif
    output branch_mispredict, issue_valid, issue_data, fu_busy, fu_done,
    output fu_output_data, cdb_accept,
    input  issue_ready, fu_input_data, fu_start, cdb_ack, cdb_valid, cdb_data
  );

endinterface

`default_nettype wire

// File: rtl/rr_arbiter.sv
// +------------------------------------------------------------------+
// | rr_arbiter : combinational one-hot arbiter, priority rotating    |
// | from ptr (first request at or after ptr, cyclically)             |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
`default_nettype none

module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0]                     req,
  input  logic [((N > 1) ? $clog2(N) : 1)-1:0] ptr,
  output logic [N-1:0]                     gnt,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] gnt_idx,
  output logic                             any
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  // Upper segment [ptr, N) is searched first, then the wrapped segment [0, ptr)
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any && req[k] && (k >= int'(ptr))) begin
        any     = 1'b1;
        gnt[k]  = 1'b1;
        gnt_idx = IW'(k);
      end
    end
    for (int k = 0; k < N; k++) begin
      if (!any && req[k]) begin
        any     = 1'b1;
        gnt[k]  = 1'b1;
        gnt_idx = IW'(k);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mult_sched.sv
// +------------------------------------------------------------------+
// | mult_sched : steers mult ops to free FUs and funnels FU results  |
// | into one registered CDB slot. Option: MULT_SCHED_PERF_EN         |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
`default_nettype none

module mult_sched
  import rv32i_types::*;
#(
  parameter int NUM_UNITS = NUM_MULT_UNITS
) (
  input  logic         clk,
  input  logic         rst,
  mult_sched_if.slave  bus
);
  localparam int IW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  logic [NUM_UNITS-1:0] occ;
  logic [NUM_UNITS-1:0] free;
  logic [NUM_UNITS-1:0] cand;
  logic [NUM_UNITS-1:0] issue_gnt;
  logic [NUM_UNITS-1:0] done_gnt;
  logic [NUM_UNITS-1:0] start;
  logic [NUM_UNITS-1:0] ack;
  logic [IW-1:0]        issue_ptr;
  logic [IW-1:0]        done_ptr;
  logic [IW-1:0]        issue_idx;
  logic [IW-1:0]        done_idx;
  logic                 issue_any;
  logic                 done_any;
  logic                 ready;
  logic                 issue_fire;
  logic                 slot_free;
  logic                 capture;
  logic                 slot_valid;
  fu_cdb_data_t         slot_data;
  logic                 busy_unused;

  function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] idx);
    return (idx == IW'(NUM_UNITS - 1)) ? '0 : idx + IW'(1);
  endfunction

  rr_arbiter #(.N(NUM_UNITS)) u_issue_arb (
    .req     (free),
    .ptr     (issue_ptr),
    .gnt     (issue_gnt),
    .gnt_idx (issue_idx),
    .any     (issue_any)
  );

  rr_arbiter #(.N(NUM_UNITS)) u_done_arb (
    .req     (cand),
    .ptr     (done_ptr),
    .gnt     (done_gnt),
    .gnt_idx (done_idx),
    .any     (done_any)
  );

  // Occupancy is tracked internally; fu_busy lags fu_start by a cycle
  assign busy_unused = ^bus.fu_busy;
  assign free        = ~occ;
  assign cand        = bus.fu_done & occ;
  assign slot_free   = ~slot_valid | bus.cdb_accept;

  assign ready      = issue_any & ~bus.branch_mispredict & ~rst;
  assign issue_fire = bus.issue_valid & ready;
  assign capture    = slot_free & done_any & ~bus.branch_mispredict & ~rst;
  assign start      = issue_fire ? issue_gnt : '0;
  assign ack        = capture ? done_gnt : '0;

  assign bus.issue_ready = ready;
  assign bus.fu_start    = start;
  assign bus.cdb_ack     = ack;
  assign bus.cdb_valid   = slot_valid;
  assign bus.cdb_data    = slot_data;

  for (genvar g = 0; g < NUM_UNITS; g++) begin : g_fu_data
    assign bus.fu_input_data[g] = bus.issue_data;
  end

  // A unit acked this cycle is not visible as free until next cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ        <= '0;
      issue_ptr  <= '0;
      done_ptr   <= '0;
      slot_valid <= 1'b0;
      slot_data  <= '0;
    end else if (bus.branch_mispredict) begin
      occ        <= '0;
      slot_valid <= 1'b0;
    end else begin
      occ <= (occ & ~ack) | start;
      if (issue_fire) begin
        issue_ptr <= ptr_inc(issue_idx);
      end
      if (capture) begin
        slot_valid <= 1'b1;
        slot_data  <= bus.fu_output_data[done_idx];
        done_ptr   <= ptr_inc(done_idx);
      end else if (bus.cdb_accept) begin
        slot_valid <= 1'b0;
      end
    end
  end

`ifdef MULT_SCHED_PERF_EN
  logic [31:0] perf_issues;
  logic [31:0] perf_stalls;
  logic [31:0] perf_blocked;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_issues  <= '0;
      perf_stalls  <= '0;
      perf_blocked <= '0;
    end else begin
      if (issue_fire) begin
        perf_issues <= perf_issues + 32'd1;
      end
      if (bus.issue_valid && !ready) begin
        perf_stalls <= perf_stalls + 32'd1;
      end
      if ((cand != '0) && !slot_free) begin
        perf_blocked <= perf_blocked + 32'd1;
      end
    end
  end

  assign bus.perf_issues      = perf_issues;
  assign bus.perf_stalls      = perf_stalls;
  assign bus.perf_cdb_blocked = perf_blocked;
`endif

endmodule

`default_nettype wire
